// File: rtl/fib_collector.sv
// Sequencer and output buffer behind the 16-bit Fibonacci generator: clears it,
// requests N terms under FIFO credit, stops cleanly on 16-bit wrap.

module fib_collector_chk #(
    parameter int DEPTH = 4,
    parameter int NW    = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          push,
    input logic [NW-1:0] count
);
    // The credit rule must never let a term land in a full FIFO.
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && (count == NW'(DEPTH))));
endmodule

module fib_collector #(
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] n_terms,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic          gen_rst,
    output logic          gen_en,
    input  logic          gen_valid,
    input  logic [15:0]   gen_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_data,
    output logic          out_last
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t        state_r, state_n;
    logic [CW-1:0] n_r, n_n;
    logic [CW-1:0] issued_r, issued_n;
    logic [CW-1:0] received_r, received_n;
    logic [15:0]   prev_r, prev_n;
    logic          ovf_r, ovf_n;
    logic          done_r, done_n;
    logic          gen_rst_r, gen_rst_n;
    logic          gen_en_r, gen_en_n;
    logic          busy_r, busy_n;

    logic [15:0]   mem_data_r [DEPTH];
    logic          mem_last_r [DEPTH];
    logic [PW-1:0] wptr_r, rptr_r;
    logic [NW-1:0] count_r, count_n, credit_s;
    logic          push_s, pop_s, wrap_s, last_s;

    // Classify an arriving term: store it, or flag wrap (a decrease after the first term).
    always_comb begin
        push_s = 1'b0;
        wrap_s = 1'b0;
        if (gen_valid && (state_r == RUN) && !ovf_r) begin
            if ((received_r != CW'(0)) && (gen_data < prev_r)) begin
                wrap_s = 1'b1;
            end else begin
                push_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
            wrap_s = 1'b0;
        end
    end

    assign pop_s  = (count_r != NW'(0)) && out_ready;
    assign last_s = ((received_r + CW'(1)) == n_r);

    // Next-state and next-output logic; gen_en is decided from the values the
    // following cycle will start with so the registered enable is on time.
    always_comb begin
        state_n    = state_r;
        n_n        = n_r;
        issued_n   = issued_r + CW'(gen_en_r);
        received_n = push_s ? (received_r + CW'(1)) : received_r;
        prev_n     = push_s ? gen_data : prev_r;
        ovf_n      = ovf_r | wrap_s;
        done_n     = 1'b0;
        gen_rst_n  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    ovf_n = 1'b0;
                    if (n_terms == CW'(0)) begin
                        done_n = 1'b1;
                    end else begin
                        state_n    = CLEAR;
                        n_n        = n_terms;
                        issued_n   = CW'(0);
                        received_n = CW'(0);
                        prev_n     = 16'd0;
                        gen_rst_n  = 1'b1;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            CLEAR: begin
                state_n = RUN;
            end
            RUN: begin
                if ((received_r == n_r) || (ovf_r && !gen_en_r)) begin
                    state_n = DRAIN;
                end else begin
                    state_n = RUN;
                end
            end
            DRAIN: begin
                if (count_r == NW'(0)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    state_n = DRAIN;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        count_n  = count_r + NW'(push_s) - NW'(pop_s);
        credit_s = count_n + NW'(gen_en_r);
        gen_en_n = (state_n == RUN) && (issued_n < n_n) && !ovf_n && (credit_s < NW'(DEPTH));
        busy_n   = (state_n != IDLE);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            n_r        <= CW'(0);
            issued_r   <= CW'(0);
            received_r <= CW'(0);
            prev_r     <= 16'd0;
            ovf_r      <= 1'b0;
            done_r     <= 1'b0;
            gen_rst_r  <= 1'b0;
            gen_en_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            n_r        <= n_n;
            issued_r   <= issued_n;
            received_r <= received_n;
            prev_r     <= prev_n;
            ovf_r      <= ovf_n;
            done_r     <= done_n;
            gen_rst_r  <= gen_rst_n;
            gen_en_r   <= gen_en_n;
            busy_r     <= busy_n;
        end
    end

    // Term FIFO storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_r[i] <= 16'd0;
                mem_last_r[i] <= 1'b0;
            end
            wptr_r  <= PW'(0);
            rptr_r  <= PW'(0);
            count_r <= NW'(0);
        end else begin
            if (push_s) begin
                mem_data_r[wptr_r] <= gen_data;
                mem_last_r[wptr_r] <= last_s;
                wptr_r             <= wptr_r + PW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PW'(1);
            end
            count_r <= count_n;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign ovf       = ovf_r;
    assign gen_rst   = gen_rst_r;
    assign gen_en    = gen_en_r;
    assign out_valid = (count_r != NW'(0));
    assign out_data  = mem_data_r[rptr_r];
    assign out_last  = mem_last_r[rptr_r];

    fib_collector_chk #(.DEPTH(DEPTH), .NW(NW)) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .count (count_r)
    );
endmodule

// File: tb/tb_fib_collector.sv
// Directed bench for fib_collector with a behavioural 16-bit Fibonacci generator.
module tb_fib_collector;
    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] n_terms;
    logic          busy, done, ovf, gen_rst, gen_en;
    logic          gen_valid;
    logic [15:0]   gen_data;
    logic          out_valid, out_ready, out_last;
    logic [15:0]   out_data;

    int checks   = 0;
    int failures = 0;
    int en_cnt, rst_cnt, done_cnt, ov_cnt;
    logic [15:0] pop_data [$];
    logic        pop_last [$];
    logic        ovf_at_done, busy_at_done;

    logic [15:0] fib_exp [0:23] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21,
                                    16'd34, 16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610,
                                    16'd987, 16'd1597, 16'd2584, 16'd4181, 16'd6765, 16'd10946,
                                    16'd17711, 16'd28657, 16'd46368};

    always #5 clk = ~clk;

    fib_collector #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_terms   (n_terms),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .gen_rst   (gen_rst),
        .gen_en    (gen_en),
        .gen_valid (gen_valid),
        .gen_data  (gen_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    // Generator: term one cycle after enable, restarts at 1,1 on its clear.
    logic [15:0] g_cur, g_nxt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            g_cur <= 16'd1; g_nxt <= 16'd1; gen_valid <= 1'b0; gen_data <= 16'd0;
        end else if (gen_rst) begin
            g_cur <= 16'd1; g_nxt <= 16'd1; gen_valid <= 1'b0;
        end else if (gen_en) begin
            gen_valid <= 1'b1; gen_data <= g_cur; g_cur <= g_nxt; g_nxt <= g_cur + g_nxt;
        end else begin
            gen_valid <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic note_pop();
        if (out_valid && out_ready) begin
            pop_data.push_back(out_data);
            pop_last.push_back(out_last);
        end
    endtask

    task automatic sample();
        if (gen_en)    en_cnt++;
        if (gen_rst)   rst_cnt++;
        if (done)      done_cnt++;
        if (out_valid) ov_cnt++;
        note_pop();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sample();
    endtask

    task automatic clear_stats();
        en_cnt = 0; rst_cnt = 0; done_cnt = 0; ov_cnt = 0;
        pop_data.delete();
        pop_last.delete();
    endtask

    task automatic do_start(input logic [CW-1:0] n);
        start   = 1'b1;
        n_terms = n;
        tick();
        start   = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done) begin
                seen         = 1'b1;
                ovf_at_done  = ovf;
                busy_at_done = busy;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic verify_terms(input string tag, input int n, input bit has_last);
        check({tag, "_count"}, 32'(pop_data.size()), 32'(n));
        for (int i = 0; i < pop_data.size() && i < 24; i++) begin
            check($sformatf("%s_data%0d", tag, i), 32'(pop_data[i]), 32'(fib_exp[i]));
            check($sformatf("%s_last%0d", tag, i), 32'(pop_last[i]), 32'(has_last && (i == n - 1)));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
        check({tag, "_gen_rst"}, 32'(gen_rst), 32'd0);
        check({tag, "_gen_en"}, 32'(gen_en), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; n_terms = 8'd0; out_ready = 1'b0;
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Basic run, N=5, with latency points
        out_ready = 1'b1;
        clear_stats();
        do_start(8'd5);
        check("basic_c1_gen_rst", 32'(gen_rst), 32'd1);
        check("basic_c1_busy", 32'(busy), 32'd1);
        check("basic_c1_gen_en", 32'(gen_en), 32'd0);
        tick();
        check("basic_c2_gen_en", 32'(gen_en), 32'd1);
        check("basic_c2_gen_rst", 32'(gen_rst), 32'd0);
        tick();
        check("basic_c3_out_valid", 32'(out_valid), 32'd0);
        tick();
        check("basic_c4_out_valid", 32'(out_valid), 32'd1);
        check("basic_c4_out_data", 32'(out_data), 32'd1);
        run_until_done("basic", 60);
        check("basic_gen_rst_cnt", 32'(rst_cnt), 32'd1);
        check("basic_gen_en_cnt", 32'(en_cnt), 32'd5);
        check("basic_ovf", 32'(ovf_at_done), 32'd0);
        check("basic_busy_at_done", 32'(busy_at_done), 32'd0);
        verify_terms("basic", 5, 1'b1);
        tick();
        check("basic_done_width", 32'(done), 32'd0);

        // Backpressure, N=10
        out_ready = 1'b0;
        clear_stats();
        do_start(8'd10);
        repeat (11) tick();
        check("bp_gen_en_cnt", 32'(en_cnt), 32'd4);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head", 32'(out_data), 32'd1);
        repeat (5) tick();
        check("bp_head_stable", 32'(out_data), 32'd1);
        check("bp_gen_en_hold", 32'(en_cnt), 32'd4);
        check("bp_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        note_pop();
        run_until_done("bp", 200);
        check("bp_gen_en_total", 32'(en_cnt), 32'd10);
        verify_terms("bp", 10, 1'b1);

        // Wrap, N=30
        clear_stats();
        do_start(8'd30);
        run_until_done("wrap", 300);
        verify_terms("wrap", 24, 1'b0);
        check("wrap_ovf_at_done", 32'(ovf_at_done), 32'd1);
        repeat (3) tick();
        check("wrap_ovf_sticky", 32'(ovf), 32'd1);

        // Restart, N=3, with start pulses while busy
        clear_stats();
        do_start(8'd3);
        check("restart_ovf_cleared", 32'(ovf), 32'd0);
        check("restart_gen_rst", 32'(gen_rst), 32'd1);
        start = 1'b1; n_terms = 8'd7;
        tick();
        tick();
        start = 1'b0;
        run_until_done("restart", 60);
        check("restart_gen_rst_cnt", 32'(rst_cnt), 32'd1);
        check("restart_gen_en_cnt", 32'(en_cnt), 32'd3);
        check("restart_ovf", 32'(ovf_at_done), 32'd0);
        verify_terms("restart", 3, 1'b1);

        // Zero count
        clear_stats();
        do_start(8'd0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        tick();
        check("zero_done_width", 32'(done), 32'd0);
        repeat (3) tick();
        check("zero_gen_rst_cnt", 32'(rst_cnt), 32'd0);
        check("zero_gen_en_cnt", 32'(en_cnt), 32'd0);
        check("zero_out_valid_cnt", 32'(ov_cnt), 32'd0);
        check("zero_done_cnt", 32'(done_cnt), 32'd1);

        // Mid-run reset after three pushes
        out_ready = 1'b0;
        clear_stats();
        do_start(8'd10);
        repeat (5) tick();
        check("midrst_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_stats();
        repeat (2) tick();
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        check("midrst_empty", 32'(ov_cnt), 32'd0);
        out_ready = 1'b1;
        do_start(8'd2);
        run_until_done("midrst_run", 60);
        verify_terms("midrst_run", 2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fib_collector.md
Name: fib_collector

Overview:
Sequencing and buffering stage directly downstream of the 16-bit Fibonacci generator. On a start command it clears the generator and requests exactly N terms through the generator's enable. It captures each valid term into a small FIFO and presents the terms to the consumer over a valid/ready interface. It detects 16-bit wrap-around in the generator and terminates the run cleanly when wrap occurs.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
CW, 8, width of term-count request and internal counters.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
start  in  1  run request; sampled only in IDLE
n_terms  in  CW  number of terms requested; latched on accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of run
ovf  out  1  sticky: run ended on generator wrap; cleared on next accepted start
gen_rst  out  1  registered one-cycle clear pulse to generator rst
gen_en  out  1  generator enable (registered)
gen_valid  in  1  generator output-valid; arrives one cycle after gen_en
gen_data  in  16  generator term value
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accept
out_data  out  16  FIFO head term
out_last  out  1  head entry is the N-th term of the run

Behaviour:
- Reset: state IDLE, FIFO empty (pointers 0); all outputs 0: busy, done, ovf, gen_rst, gen_en, out_valid, out_last, out_data=0. Counters issued, received and prev are 0.
- Reset mid-run: the block aborts immediately and flushes the FIFO. No done pulse is generated.
- States: IDLE, CLEAR, RUN, DRAIN.
- IDLE, start=1, n_terms=0: clear ovf; pulse done next cycle; stay in IDLE. No gen_rst, no gen_en.
- IDLE, start=1, n_terms>0: latch N; clear ovf, issued, received and prev; go to CLEAR.
- CLEAR: gen_rst=1 for exactly one cycle, then go to RUN.
- RUN: gen_en=1 in a cycle only when all of the following hold:
  - issued<N;
  - no wrap has been detected this run;
  - occupancy + inflight < DEPTH, where inflight is the previous cycle's gen_en and occupancy is the value at the start of the cycle. No credit is taken for a same-cycle pop.
  - Each gen_en cycle increments issued.
- Capture: on gen_valid in RUN with no wrap detected:
  - If received>0 and gen_data<prev: wrap. Do not write the value; set ovf; stop issuing gen_en.
  - Otherwise push gen_data, tagging last=1 when received+1==N. Then increment received and set prev=gen_data.
  - Equal values (1,1) are not a wrap.
- gen_valid in IDLE, CLEAR or DRAIN, or after wrap: ignored (value discarded).
- RUN exits to DRAIN when received==N, or when ovf=1 and inflight==0.
- DRAIN: when the FIFO is empty, pulse done for one cycle, go to IDLE, and deassert busy in the same cycle.
- start while busy is ignored.
- FIFO: push on the capture condition above; pop when out_valid & out_ready. Simultaneous push and pop are allowed; occupancy is unchanged.
- Pop when empty: no effect. Overflow cannot occur because of the credit rule; assertion: no push when full.
- out_valid = !empty. out_data and out_last are the head entry, combinational from storage. Head data stays stable while out_valid & !out_ready.
- Latency with out_ready=1:
  - start accepted at cycle 0;
  - gen_rst at cycle 1;
  - first gen_en at cycle 2;
  - gen_valid and push at cycle 3;
  - out_valid with data 1 at cycle 4.
- Sustained throughput is one term per cycle when DEPTH≥3.
- Generator sequence after clear: 1,1,2,3,5,…,46368 (24 terms). The 25th term wraps to 9489 and is never output.

Test Plan:
- Basic run: start, N=5, out_ready=1 -> gen_rst pulses once; gen_en high exactly 5 cycles; out_data 1,1,2,3,5 with out_last only on 5; done 1 cycle after FIFO empty; ovf=0.
- Backpressure: N=10, out_ready=0 -> gen_en stops after 4 issues (DEPTH=4); out_valid=1, out_data=1 held stable. Then raise out_ready -> 1,1,2,3,5,8,13,21,34,55 in order with none lost; out_last on 55.
- Wrap: N=30 -> 24 terms ending at 46368, none with out_last; 9489 never appears; ovf=1 at done; ovf stays 1 until next start.
- Restart: after run 1, start N=3 -> new gen_rst pulse; output 1,1,2; ovf cleared; start pulses during busy have no effect.
- Zero count: start with N=0 -> done pulse next cycle; no gen_rst, no gen_en, no out_valid.
- Mid-run reset: assert rst after 3 terms are pushed -> all outputs 0 immediately; FIFO empty. Then start N=2 -> output 1,1 and done.
